// File: rtl/pwm_gate_driver_pkg.sv
// rtl/pwm_gate_driver_pkg.sv - shared types, defaults and helpers for the three-phase gate driver
package pwm_gate_driver_pkg;

    localparam int DEFAULT_DEAD_CYCLES = 100;
    localparam int DEFAULT_CARRIER_MAX = 3125;
    localparam int DEAD_W              = 10;

    typedef enum logic [2:0] {
        LEG_IDLE      = 3'd0,
        LEG_LOW_ON    = 3'd1,
        LEG_DEAD_RISE = 3'd2,
        LEG_HIGH_ON   = 3'd3,
        LEG_DEAD_FALL = 3'd4
    } leg_state_t;

    // Saturate a signed reference into [-limit, +limit]; limit is positive.
    function automatic logic signed [15:0] clamp_ref(input logic signed [15:0] value,
                                                     input logic signed [15:0] limit);
        logic signed [15:0] result;
        result = value;
        if (value > limit) begin
            result = limit;
        end else if (value < -limit) begin
            result = -limit;
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_gate_driver_leg.sv
// rtl/pwm_gate_driver_leg.sv - one inverter leg: demand compare, dead-time FSM and gate decode
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   clk_enable        global enable; all state holds while low
//   pwm_en            low forces the leg to IDLE (both switches off)
//   active_ref        clamped, peak-synchronised phase reference
//   carrier           signed triangle carrier
//   gate_h, gate_l    high-/low-side switch commands
module pwm_leg
    import pwm_gate_driver_pkg::*;
#(
    parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               pwm_en,
    input  logic signed [15:0] active_ref,
    input  logic signed [15:0] carrier,
    output logic               gate_h,
    output logic               gate_l
);

    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

    leg_state_t        state;
    leg_state_t        state_next;
    logic [DEAD_W-1:0] dead_cnt;
    logic [DEAD_W-1:0] dead_cnt_next;
    logic              demand;

    // Registered comparison; ties resolve to the low side.
    always_ff @(posedge clk) begin
        if (reset) begin
            demand <= 1'b0;
        end else if (clk_enable) begin
            demand <= (active_ref > carrier);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LEG_IDLE;
            dead_cnt <= '0;
        end else if (clk_enable) begin
            state    <= state_next;
            dead_cnt <= dead_cnt_next;
        end
    end

    // Both dead states always run the full count; the side chosen at the end
    // follows the demand seen then, so a reversal mid-count never restarts it.
    always_comb begin
        state_next    = state;
        dead_cnt_next = dead_cnt;
        if (!pwm_en) begin
            state_next    = LEG_IDLE;
            dead_cnt_next = '0;
        end else begin
            case (state)
                LEG_IDLE: begin
                    state_next    = demand ? LEG_DEAD_RISE : LEG_DEAD_FALL;
                    dead_cnt_next = DEAD_LOAD;
                end
                LEG_LOW_ON: begin
                    if (demand) begin
                        state_next    = LEG_DEAD_RISE;
                        dead_cnt_next = DEAD_LOAD;
                    end
                end
                LEG_HIGH_ON: begin
                    if (!demand) begin
                        state_next    = LEG_DEAD_FALL;
                        dead_cnt_next = DEAD_LOAD;
                    end
                end
                LEG_DEAD_RISE, LEG_DEAD_FALL: begin
                    if (dead_cnt != '0) begin
                        dead_cnt_next = dead_cnt - 1'b1;
                    end else begin
                        state_next = demand ? LEG_HIGH_ON : LEG_LOW_ON;
                    end
                end
                default: begin
                    state_next    = LEG_IDLE;
                    dead_cnt_next = '0;
                end
            endcase
        end
    end

    // Pure state decode: the two gates can never be on together.
    always_comb begin
        gate_h = (state == LEG_HIGH_ON);
        gate_l = (state == LEG_LOW_ON);
    end

endmodule

// File: rtl/pwm_gate_driver.sv
// rtl/pwm_gate_driver.sv - three-phase PWM gate driver with dead-time insertion
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   clk_enable / ce_out        global enable in, echoed out
//   carrier                    signed triangle carrier, -CARRIER_MAX..+CARRIER_MAX
//   ref_a, ref_b, ref_c        signed phase references, qualified by ref_valid
//   pwm_en                     low forces all switches off
//   gate_ah .. gate_cl         high/low-side switch commands per phase
module pwm_gate_driver
    import pwm_gate_driver_pkg::*;
#(
    parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES,
    parameter int CARRIER_MAX = DEFAULT_CARRIER_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_enable,
    output logic               ce_out,
    input  logic signed [15:0] carrier,
    input  logic signed [15:0] ref_a,
    input  logic signed [15:0] ref_b,
    input  logic signed [15:0] ref_c,
    input  logic               ref_valid,
    input  logic               pwm_en,
    output logic               gate_ah,
    output logic               gate_al,
    output logic               gate_bh,
    output logic               gate_bl,
    output logic               gate_ch,
    output logic               gate_cl
);

    localparam logic signed [15:0] LIMIT = 16'(CARRIER_MAX);

    logic signed [15:0] shadow_a, shadow_b, shadow_c;
    logic signed [15:0] active_a, active_b, active_c;
    logic               at_turn;

    assign ce_out  = clk_enable;
    assign at_turn = (carrier == LIMIT) || (carrier == -LIMIT);

    // Non-blocking update means a strobe coinciding with a peak/valley lands
    // in the shadow only; the active copy takes the previous shadow value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_a <= '0;
            shadow_b <= '0;
            shadow_c <= '0;
            active_a <= '0;
            active_b <= '0;
            active_c <= '0;
        end else if (clk_enable) begin
            if (ref_valid) begin
                shadow_a <= clamp_ref(ref_a, LIMIT);
                shadow_b <= clamp_ref(ref_b, LIMIT);
                shadow_c <= clamp_ref(ref_c, LIMIT);
            end
            if (at_turn) begin
                active_a <= shadow_a;
                active_b <= shadow_b;
                active_c <= shadow_c;
            end
        end
    end

    pwm_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_a (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .pwm_en     (pwm_en),
        .active_ref (active_a),
        .carrier    (carrier),
        .gate_h     (gate_ah),
        .gate_l     (gate_al)
    );

    pwm_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_b (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .pwm_en     (pwm_en),
        .active_ref (active_b),
        .carrier    (carrier),
        .gate_h     (gate_bh),
        .gate_l     (gate_bl)
    );

    pwm_leg #(.DEAD_CYCLES(DEAD_CYCLES)) u_leg_c (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .pwm_en     (pwm_en),
        .active_ref (active_c),
        .carrier    (carrier),
        .gate_h     (gate_ch),
        .gate_l     (gate_cl)
    );

endmodule

// File: tb/tb_pwm_gate_driver.sv
// tb/tb_pwm_gate_driver.sv - scoreboard bench for pwm_gate_driver
module tb_pwm_gate_driver;

    localparam int DEAD = 4;
    localparam int CMAX = 3125;

    logic               clk = 1'b0;
    logic               reset;
    logic               clk_enable;
    logic               ce_out;
    logic signed [15:0] carrier;
    logic signed [15:0] ref_a, ref_b, ref_c;
    logic               ref_valid;
    logic               pwm_en;
    logic               gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl;

    always #5 clk = ~clk;

    pwm_gate_driver #(.DEAD_CYCLES(DEAD), .CARRIER_MAX(CMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .ce_out     (ce_out),
        .carrier    (carrier),
        .ref_a      (ref_a),
        .ref_b      (ref_b),
        .ref_c      (ref_c),
        .ref_valid  (ref_valid),
        .pwm_en     (pwm_en),
        .gate_ah    (gate_ah),
        .gate_al    (gate_al),
        .gate_bh    (gate_bh),
        .gate_bl    (gate_bl),
        .gate_ch    (gate_ch),
        .gate_cl    (gate_cl)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, observed, observed, expected, expected, $time);
        end
    endtask

    // Behavioural model: mode 0 = off/idle, 1 = conducting on side m_hi,
    // 2 = dead with m_left off-clocks still to spend.
    logic signed [15:0] m_shadow [3];
    logic signed [15:0] m_active [3];
    logic               m_demand [3];
    int                 m_mode   [3];
    logic               m_hi     [3];
    int                 m_left   [3];
    logic [6:0]         exp_q [$];

    function automatic logic signed [15:0] lim(input logic signed [15:0] v);
        if (int'(v) > CMAX)  return 16'(CMAX);
        if (int'(v) < -CMAX) return 16'(-CMAX);
        return v;
    endfunction

    task automatic model_clock();
        logic signed [15:0] r [3];
        r[0] = ref_a;
        r[1] = ref_b;
        r[2] = ref_c;
        for (int p = 0; p < 3; p++) begin
            if (reset) begin
                m_shadow[p] = '0;
                m_active[p] = '0;
                m_demand[p] = 1'b0;
                m_mode[p]   = 0;
                m_hi[p]     = 1'b0;
                m_left[p]   = 0;
            end else if (clk_enable) begin
                if (!pwm_en) begin
                    m_mode[p] = 0;
                end else if (m_mode[p] == 0) begin
                    m_mode[p] = 2;
                    m_left[p] = DEAD;
                end else if (m_mode[p] == 1) begin
                    if (m_demand[p] != m_hi[p]) begin
                        m_mode[p] = 2;
                        m_left[p] = DEAD;
                    end
                end else if (m_left[p] == 1) begin
                    m_mode[p] = 1;
                    m_hi[p]   = m_demand[p];
                end else begin
                    m_left[p]--;
                end
                m_demand[p] = (m_active[p] > carrier);
                if (int'(carrier) == CMAX || int'(carrier) == -CMAX) m_active[p] = m_shadow[p];
                if (ref_valid) m_shadow[p] = lim(r[p]);
            end
        end
    endtask

    function automatic logic [6:0] model_gates();
        logic [6:0] v;
        v[6] = clk_enable;
        for (int p = 0; p < 3; p++) begin
            v[5-2*p] = (m_mode[p] == 1) &&  m_hi[p];
            v[4-2*p] = (m_mode[p] == 1) && !m_hi[p];
        end
        return v;
    endfunction

    // Carrier source and run-length statistics.
    logic manual   = 1'b0;
    logic dir_up   = 1'b1;
    logic stats_on = 1'b0;
    int   step_idx = 0;
    int   a_hi_run = 0, a_last_hi = 0, a_off_run = 0, a_off_seen = 0, a_bad_off = 0;
    int   c_hi_run = 0, c_last_hi = 0;
    logic bh_seen = 1'b0, bl_dropped = 1'b0;

    task automatic update_stats();
        if (!stats_on || reset || !clk_enable) return;
        if (gate_ah) a_hi_run++;
        else if (a_hi_run > 0) begin a_last_hi = a_hi_run; a_hi_run = 0; end
        if (!gate_ah && !gate_al) a_off_run++;
        else if (a_off_run > 0) begin
            a_off_seen++;
            if (a_off_run != DEAD) a_bad_off++;
            a_off_run = 0;
        end
        if (gate_ch) c_hi_run++;
        else if (c_hi_run > 0) begin c_last_hi = c_hi_run; c_hi_run = 0; end
        if (step_idx > 2*CMAX) begin
            if (gate_bh)  bh_seen    = 1'b1;
            if (!gate_bl) bl_dropped = 1'b1;
        end
    endtask

    task automatic step();
        logic [6:0] obs;
        logic [6:0] exp_v;
        model_clock();
        exp_q.push_back(model_gates());
        @(posedge clk);
        #1;
        obs   = {ce_out, gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl};
        exp_v = exp_q.pop_front();
        check_value("gates", 32'(obs), 32'(exp_v));
        update_stats();
        if (!manual && clk_enable && !reset) begin
            carrier = dir_up ? carrier + 16'sd1 : carrier - 16'sd1;
            if (int'(carrier) == CMAX)  dir_up = 1'b0;
            if (int'(carrier) == -CMAX) dir_up = 1'b1;
        end
    endtask

    int c_snap;
    int glitch_off;
    logic glitch_al;

    initial begin
        reset      = 1'b1;
        clk_enable = 1'b1;
        pwm_en     = 1'b1;
        ref_valid  = 1'b0;
        ref_a      = '0;
        ref_b      = '0;
        ref_c      = '0;
        carrier    = 16'(-CMAX);
        for (int i = 0; i < 3; i++) step();
        check_value("reset_gates", 32'({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}), 0);

        // Free-running triangle; the first strobe coincides with the valley.
        reset    = 1'b0;
        ref_b    = -16'sd4000;
        stats_on = 1'b1;
        c_snap   = 0;
        for (int i = 0; i <= 5*CMAX*2; i++) begin
            step_idx  = i;
            ref_valid = (i == 0) || (i == 5*CMAX);
            if (i == 5*CMAX) ref_c = 16'sd1000;
            step();
            if (i == 6*CMAX) c_snap = c_last_hi;
        end
        ref_valid = 1'b0;
        stats_on  = 1'b0;
        check_value("a_high_run", a_last_hi, 2*CMAX - 1 - DEAD);
        check_value("a_bad_dead_runs", a_bad_off, 0);
        check_value("a_dead_runs_seen", a_off_seen >= 4, 1);
        check_value("b_high_seen", bh_seen, 0);
        check_value("b_low_dropped", bl_dropped, 0);
        check_value("b_low_now", gate_bl, 1);
        check_value("c_run_before_peak", c_snap, 2*CMAX - 1 - DEAD);
        check_value("c_run_after_peak", c_last_hi, 2*(1000 + CMAX) - 1 - DEAD);

        // Directly driven carrier: a demands high, then a one-clock glitch low.
        manual  = 1'b1;
        carrier = -16'sd10;
        for (int i = 0; i < 12; i++) step();
        check_value("a_high_before_glitch", gate_ah, 1);
        carrier = 16'sd10;
        step();
        carrier    = -16'sd10;
        glitch_off = 0;
        glitch_al  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gate_al) glitch_al = 1'b1;
            if (gate_ah) break;
            if (!gate_al) glitch_off++;
        end
        check_value("glitch_dead_len", glitch_off, DEAD);
        check_value("glitch_low_side", glitch_al, 0);
        check_value("glitch_recovered", gate_ah, 1);

        // pwm_en drop from HIGH_ON, then reset in the middle of DEAD_RISE.
        pwm_en = 1'b0;
        step();
        check_value("pwm_en_off", 32'({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}), 0);
        pwm_en = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        check_value("reset_mid_dead", 32'({gate_ah, gate_al, gate_bh, gate_bl, gate_ch, gate_cl}), 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Freeze inside DEAD_RISE: two enabled dead clocks, hold, then two more.
        pwm_en = 1'b0;
        step();
        pwm_en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        clk_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_value("frozen_ah", gate_ah, 0);
        end
        clk_enable = 1'b1;
        step();
        check_value("resume_dead_last", gate_ah, 0);
        step();
        check_value("resume_turn_on", gate_ah, 1);
        for (int i = 0; i < 5; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
